// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner with frame-synchronous score updates over a valid/ack handshake.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned REFRESH_DIV = 65000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    score_valid,
   output logic                    update_ack,
   output logic [NUM_DIGITS-1:0]   segment_digit,
   output logic [6:0]              segment_data
);

   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DivW = $clog2(REFRESH_DIV);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
   localparam logic [DivW-1:0] LastDiv = DivW'(REFRESH_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] FirstDigit = NUM_DIGITS'(1) << (NUM_DIGITS - 1);

   logic [DivW-1:0]         div_q, div_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
   logic [4*NUM_DIGITS-1:0] display_q, display_d;
   logic                    pending_q, pending_d;
   logic                    ack_q, ack_d;
   logic [NUM_DIGITS-1:0]   digit_q, digit_d;
   logic [6:0]              data_q, data_d;
   logic                    tick, load;
   logic [3:0]              nibble;
   logic [6:0]              seg;
`ifdef SEG_LZ_BLANK_EN
   logic                    zero_above, blank;
`endif

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h00;
      endcase
   endfunction

   always_comb begin
      tick      = (div_q == LastDiv);
      // A frame boundary only commits a value that was pending before this cycle.
      load      = tick && (idx_q == '0) && pending_q;
      div_d     = tick ? '0 : div_q + DivW'(1);
      idx_d     = idx_q;
      if (tick) begin
         idx_d = (idx_q == '0) ? LastIdx : idx_q - IdxW'(1);
      end
      staging_d = score_valid ? bcd_in : staging_q;
      pending_d = score_valid || (pending_q && !load);
      display_d = load ? staging_q : display_q;
      ack_d     = load;

      nibble = '0;
`ifdef SEG_LZ_BLANK_EN
      zero_above = 1'b1;
      blank      = 1'b0;
`endif
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
`ifdef SEG_LZ_BLANK_EN
         zero_above = zero_above && (display_d[4*i +: 4] == 4'd0);
`endif
         if (idx_d == IdxW'(i)) begin
            nibble = display_d[4*i +: 4];
`ifdef SEG_LZ_BLANK_EN
            blank  = zero_above && (i != 0);
`endif
         end
      end
      seg = decode(nibble);
`ifdef SEG_LZ_BLANK_EN
      if (blank) seg = 7'h00;
`endif

      digit_d = tick ? (NUM_DIGITS'(1) << idx_d) : digit_q;
      data_d  = tick ? seg : data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q     <= '0;
         idx_q     <= LastIdx;
         staging_q <= '0;
         display_q <= '0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         digit_q   <= FirstDigit;
         data_q    <= '0;
      end else begin
         div_q     <= div_d;
         idx_q     <= idx_d;
         staging_q <= staging_d;
         display_q <= display_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         digit_q   <= digit_d;
         data_q    <= data_d;
      end
   end

   assign update_ack    = ack_q;
   assign segment_digit = digit_q;
   assign segment_data  = data_q;

endmodule
